// File: rtl/ram_ctrl_if.sv
// ram_ctrl_if: MMU-to-RAM port bundle.
//   Data port : paddr, dout_ram, dlen_ram, we_ram, re_ram (requester -> RAM)
//               din_back, d_ready, d_valid, d_fault     (RAM -> requester)
//   Fetch port: iaddr_ram (requester -> RAM); iin_back, i_fault (RAM -> requester)
// Byte lanes are big-endian: the lowest-addressed byte sits in the MSB lane.
interface ram_ctrl_if #(
    parameter int unsigned PLEN = 64,
    parameter int unsigned DLEN = 64,
    parameter int unsigned ILEN = 32
);
    logic [PLEN-1:0] paddr;
    logic [DLEN-1:0] dout_ram;
    logic [1:0]      dlen_ram;
    logic            we_ram;
    logic            re_ram;
    logic [DLEN-1:0] din_back;
    logic            d_ready;
    logic            d_valid;
    logic            d_fault;
    logic [PLEN-1:0] iaddr_ram;
    logic [ILEN-1:0] iin_back;
    logic            i_fault;

    modport master (
        output paddr, dout_ram, dlen_ram, we_ram, re_ram, iaddr_ram,
        input  din_back, d_ready, d_valid, d_fault, iin_back, i_fault
    );

    modport slave (
        input  paddr, dout_ram, dlen_ram, we_ram, re_ram, iaddr_ram,
        output din_back, d_ready, d_valid, d_fault, iin_back, i_fault
    );
endinterface

// File: rtl/ram_ctrl.sv
// ram_ctrl: physical memory owner below the MMU. A word array of DEPTH x 64 bit
// serves a registered instruction fetch port and a ready/valid data port with
// byte-lane masked writes.
// Ports: clk, rst_n (async, active-low), bus (ram_ctrl_if.slave).
// Build option: RAM_CTRL_SPLIT_EN -- when defined, data accesses crossing a
// doubleword boundary are carried out in two beats; otherwise they fault.
module ram_ctrl #(
    parameter int unsigned PLEN  = 64,
    parameter int unsigned DLEN  = 64,
    parameter int unsigned ILEN  = 32,
    parameter int unsigned DEPTH = 4096
) (
    input  logic       clk,
    input  logic       rst_n,
    ram_ctrl_if.slave  bus
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned WW = PLEN - 3;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] BEAT0 = 2'd1;
`ifdef RAM_CTRL_SPLIT_EN
    localparam logic [1:0] BEAT1 = 2'd2;
`endif
    localparam logic [1:0] DONE  = 2'd3;

    logic [DLEN-1:0] mem [DEPTH];

    logic [1:0]      state_q, state_d;
    logic            d_ready_q, d_ready_d;
    logic            d_valid_q, d_valid_d;
    logic            d_fault_q, d_fault_d;
    logic [DLEN-1:0] din_q, din_d;
    logic [AW-1:0]   idx_q, idx_d;
    logic [2:0]      off_q, off_d;
    logic [3:0]      n_q, n_d;
    logic [DLEN-1:0] wdata_q, wdata_d;
    logic            we_q, we_d;
    logic            fault_q, fault_d;
    logic [DLEN-1:0] rdata_q, rdata_d;
    logic [ILEN-1:0] iin_q, iin_d;
    logic            ifault_q;

    logic            wr_en;
    logic [AW-1:0]   wr_idx;
    logic [DLEN-1:0] wr_data, wr_mask;

    // Bit mask covering byte lanes lo .. hi-1 (lane 0 = MSB byte)
    function automatic logic [DLEN-1:0] lane_mask(input logic [3:0] lo, input logic [3:0] hi);
        logic [DLEN-1:0] m;
        m = '0;
        for (int j = 0; j < 8; j++) begin
            m[DLEN-1-8*j -: 8] = ((4'(j) >= lo) && (4'(j) < hi)) ? 8'hFF : 8'h00;
        end
        return m;
    endfunction

    // Request decode in IDLE
    logic [WW-1:0] req_idx;
    logic [2:0]    in_off;
    logic [3:0]    in_n, in_end;
    logic          in_cross, in_fault;

    assign req_idx  = bus.paddr[PLEN-1:3];
    assign in_off   = bus.paddr[2:0];
    assign in_n     = 4'd1 << bus.dlen_ram;
    assign in_end   = {1'b0, in_off} + in_n;
    assign in_cross = in_end > 4'd8;

`ifdef RAM_CTRL_SPLIT_EN
    // A split must have its second word in range too, so no partial write happens
    assign in_fault = (bus.re_ram && bus.we_ram) || (req_idx >= WW'(DEPTH)) ||
                      (in_cross && (req_idx >= WW'(DEPTH - 1)));
`else
    assign in_fault = (bus.re_ram && bus.we_ram) || (req_idx >= WW'(DEPTH)) || in_cross;
`endif

    // Latched-request geometry: head beat bytes and shift amounts
    logic [3:0]      end_q, head_n;
    logic            cross_q;
    logic [5:0]      sh_off;
    logic [DLEN-1:0] word0;

    assign end_q   = {1'b0, off_q} + n_q;
    assign cross_q = end_q > 4'd8;
    assign head_n  = cross_q ? (4'd8 - {1'b0, off_q}) : n_q;
    assign sh_off  = {off_q, 3'b000};
    assign word0   = mem[idx_q];

`ifdef RAM_CTRL_SPLIT_EN
    logic [3:0]      rem_n;
    logic [6:0]      sh_head;
    logic [AW-1:0]   idx_nx;
    logic [DLEN-1:0] word1;

    assign rem_n   = end_q - 4'd8;
    assign sh_head = {head_n, 3'b000};
    assign idx_nx  = idx_q + AW'(1);
    assign word1   = mem[idx_nx];
`endif

    // Next state, datapath and output next values
    always_comb begin
        state_d   = state_q;
        d_ready_d = 1'b0;
        d_valid_d = 1'b0;
        d_fault_d = 1'b0;
        din_d     = din_q;
        idx_d     = idx_q;
        off_d     = off_q;
        n_d       = n_q;
        wdata_d   = wdata_q;
        we_d      = we_q;
        fault_d   = fault_q;
        rdata_d   = rdata_q;
        wr_en     = 1'b0;
        wr_idx    = idx_q;
        wr_data   = '0;
        wr_mask   = '0;
        case (state_q)
            IDLE: begin
                d_ready_d = 1'b1;
                if (d_ready_q && (bus.re_ram || bus.we_ram)) begin
                    idx_d     = bus.paddr[AW+2:3];
                    off_d     = in_off;
                    n_d       = in_n;
                    wdata_d   = bus.dout_ram;
                    we_d      = bus.we_ram;
                    fault_d   = in_fault;
                    rdata_d   = '0;
                    d_ready_d = 1'b0;
                    state_d   = in_fault ? DONE : BEAT0;
                end
            end
            BEAT0: begin
                if (we_q) begin
                    wr_en   = 1'b1;
                    wr_data = wdata_q >> sh_off;
                    wr_mask = lane_mask({1'b0, off_q}, end_q);
                end else begin
                    rdata_d = (word0 << sh_off) & lane_mask(4'd0, head_n);
                end
`ifdef RAM_CTRL_SPLIT_EN
                state_d = cross_q ? BEAT1 : DONE;
`else
                state_d = DONE;
`endif
            end
`ifdef RAM_CTRL_SPLIT_EN
            BEAT1: begin
                if (we_q) begin
                    wr_en   = 1'b1;
                    wr_idx  = idx_nx;
                    wr_data = wdata_q << sh_head;
                    wr_mask = lane_mask(4'd0, rem_n);
                end else begin
                    rdata_d = rdata_q | ((word1 & lane_mask(4'd0, rem_n)) >> sh_head);
                end
                state_d = DONE;
            end
`endif
            DONE: begin
                d_valid_d = 1'b1;
                d_fault_d = fault_q;
                din_d     = fault_q ? '0 : rdata_q;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Fetch: registered 32-bit half selected by iaddr_ram[2]
    logic [WW-1:0]   i_idx;
    logic            i_bad;
    logic [DLEN-1:0] iword;

    assign i_idx = bus.iaddr_ram[PLEN-1:3];
    assign i_bad = (bus.iaddr_ram[1:0] != 2'b00) || (i_idx >= WW'(DEPTH));
    assign iword = mem[bus.iaddr_ram[AW+2:3]];
    assign iin_d = i_bad ? '0 : (bus.iaddr_ram[2] ? iword[ILEN-1:0] : iword[DLEN-1 -: ILEN]);

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            d_ready_q <= 1'b0;
            d_valid_q <= 1'b0;
            d_fault_q <= 1'b0;
            din_q     <= '0;
            idx_q     <= '0;
            off_q     <= '0;
            n_q       <= '0;
            wdata_q   <= '0;
            we_q      <= 1'b0;
            fault_q   <= 1'b0;
            rdata_q   <= '0;
            iin_q     <= '0;
            ifault_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            d_ready_q <= d_ready_d;
            d_valid_q <= d_valid_d;
            d_fault_q <= d_fault_d;
            din_q     <= din_d;
            idx_q     <= idx_d;
            off_q     <= off_d;
            n_q       <= n_d;
            wdata_q   <= wdata_d;
            we_q      <= we_d;
            fault_q   <= fault_d;
            rdata_q   <= rdata_d;
            iin_q     <= iin_d;
            ifault_q  <= i_bad;
        end
    end

    // Memory array: byte-masked write, contents survive reset
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_idx] <= (mem[wr_idx] & ~wr_mask) | (wr_data & wr_mask);
        end
    end

    assign bus.d_ready  = d_ready_q;
    assign bus.d_valid  = d_valid_q;
    assign bus.d_fault  = d_fault_q;
    assign bus.din_back = din_q;
    assign bus.iin_back = iin_q;
    assign bus.i_fault  = ifault_q;
endmodule

// File: tb/tb_ram_ctrl.sv
// tb_ram_ctrl: directed self-checking bench for ram_ctrl (either build option).
module tb_ram_ctrl;
    localparam int unsigned DEPTH = 4096;
    localparam logic [63:0] TOP   = 64'(DEPTH * 8);

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    ram_ctrl_if bus ();

    ram_ctrl #(.DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One data request: wait for ready, present for one edge, check completion
    task automatic req(input string tag, input logic r, input logic w, input logic [63:0] a,
                       input logic [1:0] len, input logic [63:0] wd, input int exp_lat,
                       input logic exp_f, input logic chk_d, input logic [63:0] exp_d);
        int k;
        k = 0;
        while (!bus.d_ready && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk({tag, "_rdy"}, 64'(bus.d_ready), 64'd1);
        bus.re_ram   = r;
        bus.we_ram   = w;
        bus.paddr    = a;
        bus.dlen_ram = len;
        bus.dout_ram = wd;
        @(negedge clk);
        bus.re_ram = 1'b0;
        bus.we_ram = 1'b0;
        bus.paddr  = '0;
        k = 0;
        while (!bus.d_valid && k < 12) begin
            @(negedge clk);
            k++;
        end
        chk({tag, "_lat"}, 64'(k), 64'(exp_lat));
        chk({tag, "_flt"}, 64'(bus.d_fault), 64'(exp_f));
        if (chk_d) chk({tag, "_dat"}, bus.din_back, exp_d);
        @(negedge clk);
        chk({tag, "_pulse"}, 64'(bus.d_valid), 64'd0);
    endtask

    task automatic fetch(input string tag, input logic [63:0] a, input logic exp_f,
                         input logic [31:0] exp_i);
        bus.iaddr_ram = a;
        @(negedge clk);
        chk({tag, "_ifl"}, 64'(bus.i_fault), 64'(exp_f));
        chk({tag, "_ins"}, 64'(bus.iin_back), 64'(exp_i));
    endtask

    initial begin
        logic seen;
        checks       = 0;
        failures     = 0;
        rst_n        = 1'b0;
        bus.paddr    = '0;
        bus.dout_ram = '0;
        bus.dlen_ram = 2'd0;
        bus.we_ram   = 1'b0;
        bus.re_ram   = 1'b0;
        bus.iaddr_ram = '0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_ready", 64'(bus.d_ready), 64'd0);
        chk("rst_valid", 64'(bus.d_valid), 64'd0);
        chk("rst_fault", 64'(bus.d_fault), 64'd0);
        chk("rst_din", bus.din_back, 64'd0);
        chk("rst_iin", 64'(bus.iin_back), 64'd0);
        chk("rst_ifault", 64'(bus.i_fault), 64'd0);
        rst_n = 1'b1;
        chk("rel_ready0", 64'(bus.d_ready), 64'd0);
        @(negedge clk);
        chk("rel_ready1", 64'(bus.d_ready), 64'd1);

        // Aligned accesses and sub-doubleword lanes
        req("w8_10", 1'b0, 1'b1, 64'h10, 2'd3, 64'h0011223344556677, 2, 1'b0, 1'b0, 64'd0);
        req("r1_13", 1'b1, 1'b0, 64'h13, 2'd0, 64'd0, 2, 1'b0, 1'b1, 64'h3300000000000000);
        req("r4_14", 1'b1, 1'b0, 64'h14, 2'd2, 64'd0, 2, 1'b0, 1'b1, 64'h4455667700000000);
        req("r2_16", 1'b1, 1'b0, 64'h16, 2'd1, 64'd0, 2, 1'b0, 1'b1, 64'h6677000000000000);
        req("w1_11", 1'b0, 1'b1, 64'h11, 2'd0, 64'h5AFFFFFFFFFFFFFF, 2, 1'b0, 1'b0, 64'd0);
        req("r8_10a", 1'b1, 1'b0, 64'h10, 2'd3, 64'd0, 2, 1'b0, 1'b1, 64'h005A223344556677);

        // Doubleword-crossing store and loads
`ifdef RAM_CTRL_SPLIT_EN
        req("w2_17", 1'b0, 1'b1, 64'h17, 2'd1, 64'hAABB000000000000, 3, 1'b0, 1'b0, 64'd0);
        req("r8_10b", 1'b1, 1'b0, 64'h10, 2'd3, 64'd0, 2, 1'b0, 1'b1, 64'h005A2233445566AA);
        req("r1_18", 1'b1, 1'b0, 64'h18, 2'd0, 64'd0, 2, 1'b0, 1'b1, 64'hBB00000000000000);
        req("r2_17", 1'b1, 1'b0, 64'h17, 2'd1, 64'd0, 3, 1'b0, 1'b1, 64'hAABB000000000000);
`else
        req("w2_17", 1'b0, 1'b1, 64'h17, 2'd1, 64'hAABB000000000000, 1, 1'b1, 1'b1, 64'd0);
        req("r8_10b", 1'b1, 1'b0, 64'h10, 2'd3, 64'd0, 2, 1'b0, 1'b1, 64'h005A223344556677);
`endif

        // Faults: conflicting direction, index at DEPTH, split off the end
        req("f_rw", 1'b1, 1'b1, 64'h10, 2'd3, 64'hFFFFFFFFFFFFFFFF, 1, 1'b1, 1'b1, 64'd0);
        req("f_oob", 1'b1, 1'b0, TOP, 2'd0, 64'd0, 1, 1'b1, 1'b1, 64'd0);
        req("f_woob", 1'b0, 1'b1, TOP + 64'h8, 2'd3, 64'hFFFFFFFFFFFFFFFF, 1, 1'b1, 1'b1, 64'd0);
`ifdef RAM_CTRL_SPLIT_EN
        req("r8_10c", 1'b1, 1'b0, 64'h10, 2'd3, 64'd0, 2, 1'b0, 1'b1, 64'h005A2233445566AA);
`else
        req("r8_10c", 1'b1, 1'b0, 64'h10, 2'd3, 64'd0, 2, 1'b0, 1'b1, 64'h005A223344556677);
`endif
        req("w8_last", 1'b0, 1'b1, TOP - 64'h8, 2'd3, 64'h0102030405060708, 2, 1'b0, 1'b0, 64'd0);
        req("f_split_end", 1'b0, 1'b1, TOP - 64'h1, 2'd1, 64'hFFFF000000000000, 1, 1'b1, 1'b1, 64'd0);
        req("r8_last", 1'b1, 1'b0, TOP - 64'h8, 2'd3, 64'd0, 2, 1'b0, 1'b1, 64'h0102030405060708);

        // Instruction fetch port
        fetch("i_14", 64'h14, 1'b0, 32'h44556677);
        fetch("i_10", 64'h10, 1'b0, 32'h005A2233);
        fetch("i_12", 64'h12, 1'b1, 32'h0);
        fetch("i_oob", TOP, 1'b1, 32'h0);
        fetch("i_last", TOP - 64'h4, 1'b0, 32'h05060708);
        bus.iaddr_ram = '0;

`ifdef RAM_CTRL_SPLIT_EN
        // Reset during BEAT1 of a split store
        req("w8_28", 1'b0, 1'b1, 64'h28, 2'd3, 64'h1111111111111111, 2, 1'b0, 1'b0, 64'd0);
        req("w8_30", 1'b0, 1'b1, 64'h30, 2'd3, 64'h2222222222222222, 2, 1'b0, 1'b0, 64'd0);
        bus.we_ram   = 1'b1;
        bus.paddr    = 64'h2E;
        bus.dlen_ram = 2'd2;
        bus.dout_ram = 64'hDEADBEEF00000000;
        @(negedge clk);
        bus.we_ram = 1'b0;
        seen = bus.d_valid;
        @(negedge clk);
        seen = seen | bus.d_valid;
        rst_n = 1'b0;
        repeat (3) begin
            @(negedge clk);
            seen = seen | bus.d_valid;
        end
        rst_n = 1'b1;
        repeat (4) begin
            @(negedge clk);
            seen = seen | bus.d_valid;
        end
        chk("rst_b1_novalid", 64'(seen), 64'd0);
        req("r8_28", 1'b1, 1'b0, 64'h28, 2'd3, 64'd0, 2, 1'b0, 1'b1, 64'h111111111111DEAD);
        req("r8_30", 1'b1, 1'b0, 64'h30, 2'd3, 64'd0, 2, 1'b0, 1'b1, 64'h2222222222222222);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
